data_cache_wt: RTL and testbench
================================

Name: data_cache_wt

Overview:
Parametrised direct-mapped, write-through, no-write-allocate data cache between the datapath data-memory port and a multi-cycle backing RAM. It generalises the existing data-memory interface with a request/ready handshake toward the core and a req/ack handshake toward memory. It also provides configurable depth, a flush command and hit/miss statistics counters.

Parameters:
ADDR_SIZE, 32, byte address width
DATA_SIZE, 32, word width; one word per line
NUM_LINES, 16, number of lines; power of two, >=2
CNT_SIZE, 32, width of hit/miss statistics counters

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
req_valid  input  1  core access request
addr  input  ADDR_SIZE  byte address; bits [1:0] ignored
write_enable  input  1  1 = store, 0 = load
write_data  input  DATA_SIZE  store data
read_data  output  DATA_SIZE  load data, valid when ready=1 and write_enable=0
hit  output  1  access completed from cache
ready  output  1  access complete this cycle
flush  input  1  invalidate all lines
mem_req  output  1  backing-memory request
mem_addr  output  ADDR_SIZE  backing-memory address (word aligned)
mem_write_enable  output  1  backing-memory store
mem_write_data  output  DATA_SIZE  backing-memory store data
mem_read_data  input  DATA_SIZE  backing-memory load data
mem_ack  input  1  backing memory done; one-cycle pulse
hit_count  output  CNT_SIZE  load hits since reset/flush
miss_count  output  CNT_SIZE  load misses since reset/flush

Behaviour:
- Address split: index = addr[2 +: log2(NUM_LINES)]; tag = remaining upper bits. Storage per line: valid, tag, data.
- Core holds addr/write_enable/write_data stable from req_valid until ready.
- FSM states: IDLE, REFILL, WRITE, RESP.
- IDLE, load hit (valid && tag match): ready=1 and hit=1 combinationally in the same cycle; read_data = line data; hit_count++. Stay IDLE.
- IDLE, load miss: miss_count++; go REFILL.
- REFILL: mem_req=1, mem_write_enable=0, mem_addr={addr[ADDR_SIZE-1:2],2'b00}. On mem_ack, write mem_read_data into the line, set valid, set tag, capture the data, go RESP.
- IDLE, store: if the line hits, update line data the same cycle. The line is never allocated on a miss. Go WRITE.
- WRITE: mem_req=1, mem_write_enable=1, mem_write_data=write_data. On mem_ack, go RESP.
- RESP: ready=1 and hit=0 for exactly one cycle. read_data = captured refill data (loads) or 0 (stores). Go IDLE.
- mem_req stays high until the cycle mem_ack is sampled and is low in every other state. mem_ack outside REFILL/WRITE is ignored.
- Outside the cycles defined above, ready=0 and hit=0. read_data=0 when ready=0.
- Stores never change the counters.
- Flush: honoured only in IDLE with req_valid=0. Next edge clears all valid bits and both counters. In other cases flush is ignored (not queued).
- Counters saturate at all-ones.
- Reset (async, any state including mid-REFILL/WRITE): state=IDLE, all valid=0, counters=0. All outputs go 0 immediately, including mem_req. A pending access is dropped and the core must reissue it.

Test Plan:
- Cold load addr=0x40, memory returns 0xDEADBEEF after 3 cycles -> mem_req high 3 cycles with mem_addr=0x40; RESP ready=1, hit=0, read_data=0xDEADBEEF; miss_count=1.
- Repeat load 0x40 -> ready=1 and hit=1 in the same cycle, read_data=0xDEADBEEF, no mem_req; hit_count=1.
- Store 0x40 data 0x12345678 -> mem_req with mem_write_enable=1 and mem_write_data=0x12345678 until ack. A following load 0x40 hits with 0x12345678.
- Conflict (NUM_LINES=16): load 0x40 then 0x80 then 0x40 -> 0x80 misses and evicts, 0x40 misses again; miss_count=3. A store to uncached 0x100 followed by load 0x100 misses (no allocate).
- Flush in IDLE after hits -> counters=0; next load 0x40 misses.
- Assert rst during REFILL -> mem_req drops the same cycle. After release, load of the same address misses and counters restart from 0.

Source files
------------

// File: rtl/data_cache_wt_if.sv
// Core-side and memory-side signal bundle for the write-through data cache.
// slave: the cache's view. master: the core and backing memory driving the cache.
// Scalar clock/reset are not part of the bundle.
interface data_cache_wt_if #(
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 32,
  parameter int CNT_SIZE  = 32
);
  // core side
  logic                 req_valid;
  logic [ADDR_SIZE-1:0] addr;
  logic                 write_enable;
  logic [DATA_SIZE-1:0] write_data;
  logic [DATA_SIZE-1:0] read_data;
  logic                 hit;
  logic                 ready;
  logic                 flush;
  // backing-memory side
  logic                 mem_req;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic                 mem_write_enable;
  logic [DATA_SIZE-1:0] mem_write_data;
  logic [DATA_SIZE-1:0] mem_read_data;
  logic                 mem_ack;
  // statistics
  logic [CNT_SIZE-1:0]  hit_count;
  logic [CNT_SIZE-1:0]  miss_count;

  modport slave (
    input  req_valid, addr, write_enable, write_data, flush, mem_read_data, mem_ack,
    output read_data, hit, ready, mem_req, mem_addr, mem_write_enable, mem_write_data,
           hit_count, miss_count
  );

  modport master (
    output req_valid, addr, write_enable, write_data, flush, mem_read_data, mem_ack,
    input  read_data, hit, ready, mem_req, mem_addr, mem_write_enable, mem_write_data,
           hit_count, miss_count
  );
endinterface

// File: rtl/data_cache_wt.sv
// Direct-mapped write-through, no-write-allocate data cache with flush and hit/miss counters.
// Latency: load hit completes combinationally in the request cycle; miss/store take memory latency + 1 (RESP).
// Backpressure: core holds its request until ready; memory request held until mem_ack.
module data_cache_wt #(
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 32,
  parameter int NUM_LINES = 16,
  parameter int CNT_SIZE  = 32
) (
  input logic          clk,
  input logic          rst,
  data_cache_wt_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_SIZE - 2 - IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_WRITE, S_RESP} state_t;

  state_t               r_state;
  logic [NUM_LINES-1:0] r_valid;
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [DATA_SIZE-1:0] r_data [NUM_LINES];
  logic [DATA_SIZE-1:0] r_resp_data;
  logic [CNT_SIZE-1:0]  r_hit_cnt;
  logic [CNT_SIZE-1:0]  r_miss_cnt;

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic w_idle, w_line_hit, w_load_hit, w_load_miss, w_store, w_flush;
  logic w_refill_done, w_write_done, w_mem_busy;
  logic w_unused;

  assign w_idx         = bus.addr[2 +: IDX_W];
  assign w_tag         = bus.addr[ADDR_SIZE-1 -: TAG_W];
  assign w_idle        = (r_state == S_IDLE);
  assign w_line_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_load_hit    = w_idle && bus.req_valid && !bus.write_enable && w_line_hit;
  assign w_load_miss   = w_idle && bus.req_valid && !bus.write_enable && !w_line_hit;
  assign w_store       = w_idle && bus.req_valid && bus.write_enable;
  // Flush only when the cache is idle and nothing is being requested; never queued.
  assign w_flush       = w_idle && !bus.req_valid && bus.flush;
  assign w_refill_done = (r_state == S_REFILL) && bus.mem_ack;
  assign w_write_done  = (r_state == S_WRITE) && bus.mem_ack;
  assign w_mem_busy    = (r_state == S_REFILL) || (r_state == S_WRITE);
  // Byte-offset bits do not select anything in a one-word-per-line cache.
  assign w_unused      = ^bus.addr[1:0];

  // Core response: hits answer in the request cycle, misses/stores answer from RESP.
  assign bus.ready     = w_load_hit || (r_state == S_RESP);
  assign bus.hit       = w_load_hit;
  assign bus.read_data = w_load_hit ? r_data[w_idx] :
                         (r_state == S_RESP) ? r_resp_data : '0;

  // Memory request is a pure function of state, so reset drops it immediately.
  assign bus.mem_req          = w_mem_busy;
  assign bus.mem_addr         = w_mem_busy ? {bus.addr[ADDR_SIZE-1:2], 2'b00} : '0;
  assign bus.mem_write_enable = (r_state == S_WRITE);
  assign bus.mem_write_data   = (r_state == S_WRITE) ? bus.write_data : '0;

  assign bus.hit_count  = r_hit_cnt;
  assign bus.miss_count = r_miss_cnt;

  // Control FSM: state, valid bits, statistics and the captured response word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_valid     <= '0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
      r_resp_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_flush) begin
            r_valid    <= '0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
          end else if (w_load_hit) begin
            if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 1'b1;
          end else if (w_load_miss) begin
            if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 1'b1;
            r_state <= S_REFILL;
          end else if (w_store) begin
            r_state <= S_WRITE;
          end
        end
        S_REFILL: begin
          if (bus.mem_ack) begin
            r_valid[w_idx] <= 1'b1;
            r_resp_data    <= bus.mem_read_data;
            r_state        <= S_RESP;
          end
        end
        S_WRITE: begin
          if (bus.mem_ack) begin
            r_resp_data <= '0;
            r_state     <= S_RESP;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Line payload: refill installs tag+data; a store updates data only if the line already hits.
  always_ff @(posedge clk) begin
    if (w_refill_done) begin
      r_tag[w_idx]  <= w_tag;
      r_data[w_idx] <= bus.mem_read_data;
    end else if (w_store && w_line_hit) begin
      r_data[w_idx] <= bus.write_data;
    end
  end
endmodule

// File: tb/tb_data_cache_wt.sv
// Scoreboard bench for data_cache_wt: a reference cache model predicts hit/read_data per access,
// expectations are queued at drive time and popped when the cache raises ready.
// A behavioural backing memory answers requests after a programmable latency.
module tb_data_cache_wt;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_cache_wt_if #(.ADDR_SIZE(32), .DATA_SIZE(32), .CNT_SIZE(32)) u_if ();

  data_cache_wt #(.ADDR_SIZE(32), .DATA_SIZE(32), .NUM_LINES(16), .CNT_SIZE(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  typedef struct {
    logic        hit;
    logic [31:0] rd;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // reference model of the cache and counters
  logic        mv [16];
  logic [25:0] mt [16];
  int          m_hits = 0;
  int          m_miss = 0;

  // backing memory
  logic [31:0] mem_arr [0:255];
  int          mem_lat    = 3;
  int          mem_cnt    = 0;
  int          mem_cycles = 0;
  logic [31:0] rec_addr   = '0;
  logic        rec_we     = 1'b0;
  logic [31:0] rec_wdata  = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Backing memory: acks after mem_lat request cycles with a one-cycle pulse.
  always @(negedge clk) begin
    u_if.mem_ack = 1'b0;
    if (u_if.mem_req && !rst) begin
      mem_cycles++;
      mem_cnt++;
      rec_addr  = u_if.mem_addr;
      rec_we    = u_if.mem_write_enable;
      rec_wdata = u_if.mem_write_data;
      if (mem_cnt >= mem_lat) begin
        u_if.mem_ack = 1'b1;
        if (u_if.mem_write_enable) begin
          mem_arr[u_if.mem_addr[9:2]] = u_if.mem_write_data;
          u_if.mem_read_data = '0;
        end else begin
          u_if.mem_read_data = mem_arr[u_if.mem_addr[9:2]];
        end
        mem_cnt = 0;
      end
    end else begin
      mem_cnt = 0;
    end
  end

  // Response monitor: pop the scoreboard on ready, otherwise outputs must be quiet.
  always @(negedge clk) begin
    if (!rst) begin
      if (u_if.ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_ready", 64'(u_if.ready), 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("hit", 64'(u_if.hit), 64'(e.hit));
          chk("read_data", 64'(u_if.read_data), 64'(e.rd));
        end
      end else begin
        chk("idle_outputs", {31'd0, u_if.hit, u_if.read_data}, 64'd0);
      end
    end
  end

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
    m_hits = 0;
    m_miss = 0;
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_hit_count"}, 64'(u_if.hit_count), 64'(m_hits));
    chk({tag, "_miss_count"}, 64'(u_if.miss_count), 64'(m_miss));
  endtask

  // One core access; fl holds flush high for the whole access (it must be ignored).
  task automatic access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input int lat, input logic fl);
    logic [3:0]  idx;
    logic [25:0] tg;
    logic        mhit;
    exp_t        e;
    int          exp_cyc;
    logic        got;
    idx  = a[5:2];
    tg   = a[31:6];
    mhit = mv[idx] && (mt[idx] == tg);
    e.hit = !we && mhit;
    e.rd  = we ? 32'd0 : mem_arr[a[9:2]];
    exp_cyc = e.hit ? 0 : lat;
    if (!we) begin
      if (mhit) m_hits++;
      else begin
        m_miss++;
        mv[idx] = 1'b1;
        mt[idx] = tg;
      end
    end
    sb.push_back(e);
    mem_lat    = lat;
    @(posedge clk);
    #1;
    mem_cycles        = 0;
    u_if.req_valid    = 1'b1;
    u_if.addr         = a;
    u_if.write_enable = we;
    u_if.write_data   = wd;
    u_if.flush        = fl;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (u_if.ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    u_if.req_valid = 1'b0;
    u_if.flush     = 1'b0;
    @(negedge clk);
    chk("ready_one_cycle", 64'(u_if.ready), 64'd0);
    chk("mem_req_cycles", 64'(mem_cycles), 64'(exp_cyc));
    if (exp_cyc > 0) begin
      chk("mem_addr", 64'(rec_addr), 64'({a[31:2], 2'b00}));
      chk("mem_we", 64'(rec_we), 64'(we));
      chk("mem_wdata", 64'(rec_wdata), we ? 64'(wd) : 64'd0);
    end
    check_counters("acc");
  endtask

  task automatic do_flush();
    @(posedge clk);
    #1;
    u_if.flush = 1'b1;
    @(posedge clk);
    #1;
    u_if.flush = 1'b0;
    model_clear();
    @(negedge clk);
    check_counters("flush");
  endtask

  initial begin
    u_if.req_valid     = 1'b0;
    u_if.addr          = '0;
    u_if.write_enable  = 1'b0;
    u_if.write_data    = '0;
    u_if.flush         = 1'b0;
    u_if.mem_read_data = '0;
    u_if.mem_ack       = 1'b0;
    for (int i = 0; i < 256; i++) mem_arr[i] = 32'hA500_0000 | (i * 32'h0001_0101);
    mem_arr[8'h10] = 32'hDEADBEEF;
    model_clear();

    // reset state
    #2;
    chk("rst_ready", 64'(u_if.ready), 64'd0);
    chk("rst_mem_req", 64'(u_if.mem_req), 64'd0);
    check_counters("rst");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // cold miss, then hit
    access(1'b0, 32'h40, 32'h0, 3, 1'b0);
    access(1'b0, 32'h40, 32'h0, 3, 1'b0);
    // store-hit updates line and memory; reload hits with new data
    access(1'b1, 32'h40, 32'h12345678, 3, 1'b0);
    access(1'b0, 32'h40, 32'h0, 3, 1'b0);
    // conflict eviction on index 0
    access(1'b0, 32'h80, 32'h0, 2, 1'b0);
    access(1'b0, 32'h40, 32'h0, 4, 1'b0);
    // store miss does not allocate
    access(1'b1, 32'h100, 32'hCAFEF00D, 1, 1'b0);
    access(1'b0, 32'h100, 32'h0, 3, 1'b0);
    // flush while busy or requesting is ignored
    access(1'b0, 32'h100, 32'h0, 3, 1'b1);
    access(1'b0, 32'h44, 32'h0, 2, 1'b1);
    // flush in idle clears counters and lines
    do_flush();
    access(1'b0, 32'h40, 32'h0, 3, 1'b0);

    // mixed traffic over a small address range with odd byte offsets
    for (int n = 0; n < 24; n++) begin
      logic [31:0] a;
      a = {22'd0, 8'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
      access(1'($urandom_range(0, 2) == 0), a, $urandom, $urandom_range(1, 4), 1'b0);
    end

    // reset during REFILL drops the request at once
    mem_lat = 3;
    @(posedge clk);
    #1;
    u_if.req_valid    = 1'b1;
    u_if.addr         = 32'h200;
    u_if.write_enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("refill_mem_req", 64'(u_if.mem_req), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_mem_req", 64'(u_if.mem_req), 64'd0);
    chk("rst_mid_ready", 64'(u_if.ready), 64'd0);
    u_if.req_valid = 1'b0;
    model_clear();
    check_counters("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    access(1'b0, 32'h200, 32'h0, 3, 1'b0);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
